uart_mem_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 8 +
 rtl/uart_rx_byte.sv | 85 ++++++++
 rtl/uart_mem_loader.sv | 125 ++++++++++++
 tb/tb_uart_mem_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared constants and state encodings for the UART memory loader
package loader_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam int DEF_BAUD_DIV = 217;
  localparam int DEF_TIMEOUT = 250000;
  typedef enum logic [2:0] {IDLE, ADR2, ADR1, ADR0, LEN1, LEN0, DATA} state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: two-flop rx synchroniser plus 8N1 byte sampler
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  rx_state_t st_q, st_d;
  logic s1_q, s1_d, s2_q, s2_d, vld_q, vld_d, ferr_q, ferr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic tick_half, tick;
  assign tick_half = cnt_q == CW'(BAUD_DIV / 2 - 1);
  assign tick = cnt_q == CW'(BAUD_DIV - 1);
  always_comb begin
    s1_d = rx;
    s2_d = s1_q;
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    vld_d = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        st_d = s2_q ? RX_IDLE : RX_START;
      end
      RX_START: if (tick_half) begin
        cnt_d = '0;
        bit_d = '0;
        st_d = s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick) begin
        cnt_d = '0;
        sh_d = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        st_d = bit_q == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (tick) begin
        cnt_d = '0;
        vld_d = s2_q;
        ferr_d = !s2_q;
        st_d = s2_q ? RX_IDLE : RX_WAIT;
      end
      RX_WAIT: begin
        cnt_d = '0;
        st_d = s2_q ? RX_IDLE : RX_WAIT;
      end
      default: st_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      st_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      vld_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      vld_q <= vld_d;
      ferr_q <= ferr_d;
    end
  end
  assign data = sh_q;
  assign byte_valid = vld_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: UART-driven byte memory bus initiator for host-side loading
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [19:0] address,
  output logic [7:0]  out,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [7:0] data;
  logic byte_valid, frame_err;
  state_t state_q, state_d;
  logic [19:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] out_q, out_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d, fin_q, fin_d;
  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .data(data),
    .byte_valid(byte_valid),
    .frame_err(frame_err)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    out_d = out_q;
    we_d = 1'b0;
    busy_d = fin_q ? 1'b0 : busy_q;
    done_d = fin_q;
    err_d = frame_err;
    fin_d = 1'b0;
    tmo_d = (byte_valid || state_q == IDLE) ? '0 : tmo_q + 1'b1;
    if (byte_valid) begin
      case (state_q)
        IDLE: if (data == CMD_WRITE) begin
          state_d = ADR2;
          busy_d = 1'b1;
        end
        ADR2: begin
          ptr_d[19:16] = data[3:0];
          state_d = ADR1;
        end
        ADR1: begin
          ptr_d[15:8] = data;
          state_d = ADR0;
        end
        ADR0: begin
          ptr_d[7:0] = data;
          state_d = LEN1;
        end
        LEN1: begin
          cnt_d[15:8] = data;
          state_d = LEN0;
        end
        LEN0: begin
          cnt_d[7:0] = data;
          state_d = cnt_d == '0 ? IDLE : DATA;
          done_d = cnt_d == '0;
          busy_d = cnt_d != '0;
        end
        DATA: begin
          we_d = 1'b1;
          addr_d = ptr_q;
          out_d = data;
          ptr_d = ptr_q + 20'd1;
          cnt_d = cnt_q - 16'd1;
          fin_d = cnt_q == 16'd1;
          state_d = cnt_q == 16'd1 ? IDLE : DATA;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
      err_d = 1'b1;
      state_d = IDLE;
      busy_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      addr_q <= '0;
      out_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      addr_q <= addr_d;
      out_q <= out_d;
      we_q <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      fin_q <= fin_d;
    end
  end
  assign address = addr_q;
  assign out = out_q;
  assign we = we_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: scoreboard bench driving serial frames and checking bus writes, done and err
module tb_uart_mem_loader;
  localparam int BAUD = 32;
  localparam int TMO = 3000;
  logic clock = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [19:0] address;
  logic [7:0] out;
  logic we, busy, done, err;
  uart_mem_loader #(.BAUD_DIV(BAUD), .TIMEOUT(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .address(address),
    .out(out),
    .we(we),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [1:0]  kind;
    logic [19:0] a;
    logic [7:0]  d;
  } ev_t;
  ev_t exp_q[$];
  logic [7:0] dq[$];
  int checks = 0, errors = 0, cyc = 0, last_we = -10, err_cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  always @(negedge clock) begin
    ev_t e;
    if (!reset) begin
      if (we) begin
        chk("we_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("we_kind", e.kind, 0);
          chk("we_addr", address, e.a);
          chk("we_data", out, e.d);
          chk("busy_at_we", busy, 1);
        end
        last_we = cyc;
      end
      if (done) begin
        chk("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("done_kind", e.kind, 1);
          chk("busy_at_done", busy, 0);
          if (e.d[0]) chk("done_after_we", cyc, last_we + 1);
        end
      end
      if (err) begin
        chk("err_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("err_kind", e.kind, 2);
          chk("busy_at_err", busy, 0);
        end
        err_cyc = cyc;
      end
    end
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    rx = 1'b0;
    wait_cyc(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(BAUD);
    end
    rx = stop;
    wait_cyc(BAUD);
    if (!stop) begin
      rx = 1'b1;
      wait_cyc(2 * BAUD);
    end
  endtask
  task automatic gap_byte(input logic [7:0] b);
    wait_cyc($urandom_range(0, 20));
    send_byte(b);
  endtask
  // mode 0: complete frame, 1: truncated then timeout, 2: truncated with no ending event
  task automatic frame(input logic [19:0] a, input logic [3:0] junk, input int len, input int nsend, input int mode);
    for (int i = 0; i < nsend; i++) exp_q.push_back('{2'd0, a + 20'(i), dq[i]});
    if (mode == 0) exp_q.push_back('{2'd1, 20'd0, {7'd0, len > 0}});
    if (mode == 1) exp_q.push_back('{2'd2, 20'd0, 8'd0});
    gap_byte(8'h57);
    gap_byte({junk, a[19:16]});
    gap_byte(a[15:8]);
    gap_byte(a[7:0]);
    gap_byte(8'(len >> 8));
    gap_byte(8'(len));
    for (int i = 0; i < nsend; i++) gap_byte(dq[i]);
  endtask
  task automatic wait_drain(input string name);
    for (int i = 0; i < 20000 && exp_q.size() > 0; i++) wait_cyc(1);
    wait_cyc(BAUD);
    chk(name, exp_q.size(), 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not end, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end
  initial begin
    int t0, len;
    logic [7:0] b;
    wait_cyc(3);
    chk_zero("reset");
    reset = 1'b0;
    wait_cyc(5);
    dq = '{8'hAA, 8'hBB, 8'hCC};
    frame(20'h00010, 4'h0, 3, 3, 0);
    wait_drain("drain_basic");
    dq = '{8'h11, 8'h22};
    frame(20'hFFFFF, 4'h5, 2, 2, 0);
    wait_drain("drain_wrap");
    frame(20'hB8000, 4'h0, 0, 0, 0);
    gap_byte(8'h41);
    gap_byte(8'h42);
    wait_drain("drain_empty");
    chk("busy_after_ignored", busy, 0);
    exp_q.push_back('{2'd2, 20'd0, 8'd0});
    send_byte(8'h57, 1'b0);
    wait_drain("drain_frame_err");
    chk("busy_after_frame_err", busy, 0);
    rx = 1'b0;
    wait_cyc(1);
    rx = 1'b1;
    wait_cyc(4 * BAUD);
    chk("busy_after_glitch", busy, 0);
    dq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    frame(20'h12345, 4'h0, 5, 2, 1);
    t0 = cyc;
    wait_drain("drain_timeout");
    chk("timeout_window", (err_cyc - t0 >= TMO - BAUD) && (err_cyc - t0 <= TMO), 1);
    chk("busy_after_timeout", busy, 0);
    dq = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    frame(20'h00400, 4'h0, 4, 2, 2);
    wait_cyc(5);
    chk("drain_pre_reset", exp_q.size(), 0);
    reset = 1'b1;
    wait_cyc(1);
    chk_zero("midreset");
    reset = 1'b0;
    wait_cyc(4 * BAUD);
    chk("no_done_after_reset", exp_q.size(), 0);
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        gap_byte(b == 8'h57 ? 8'h58 : b);
      end
      len = $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 6);
      dq = {};
      for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
      frame(20'($urandom), 4'($urandom), len, len, 0);
    end
    wait_drain("drain_random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
